// File: rtl/cpu_clock_ctrl.sv
// CPU clock generator: free-running divided clock or one debounced single-step period per press.
// Define CYCLE_COUNTER_EN to build the issued-cycle counter; otherwise cycle_cnt is tied to zero.
module cpu_clock_ctrl #(
   parameter int unsigned DIV_N = 32'd10000000,
   parameter int unsigned DEB_N = 32'd1000000
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        run,
   input  logic        btn_step,
   output logic        cpu_clk,
   output logic        busy,
   output logic [31:0] cycle_cnt
);

   localparam logic [31:0] DIV_LAST = 32'(DIV_N);
   localparam logic [31:0] DEB_LAST = 32'(DEB_N - 32'd1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_HI  = 3'd1,
      RUN_LO  = 3'd2,
      STEP_HI = 3'd3,
      STEP_LO = 3'd4
   } state_t;

   logic        run_meta_r;
   logic        run_sync_r;
   logic        btn_meta_r;
   logic        btn_sync_r;
   logic [31:0] deb_cnt_r;
   logic        btn_db_r;
   logic        btn_db_d_r;
   logic        step_req_s;
   logic [31:0] div_cnt_r;
   logic        div_done_s;
   state_t      state_r;
   logic        cpu_clk_r;
   logic        busy_r;

   // Two-flop synchronisers for the switch and the raw button
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         run_meta_r <= 1'b0;
         run_sync_r <= 1'b0;
         btn_meta_r <= 1'b0;
         btn_sync_r <= 1'b0;
      end else begin
         run_meta_r <= run;
         run_sync_r <= run_meta_r;
         btn_meta_r <= btn_step;
         btn_sync_r <= btn_meta_r;
      end
   end

   // Debounce filter: a new level is accepted only after DEB_N stable cycles
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         deb_cnt_r  <= 32'd0;
         btn_db_r   <= 1'b0;
         btn_db_d_r <= 1'b0;
      end else begin
         btn_db_d_r <= btn_db_r;
         if (btn_sync_r == btn_db_r) begin
            deb_cnt_r <= 32'd0;
         end else if (deb_cnt_r == DEB_LAST) begin
            btn_db_r  <= btn_sync_r;
            deb_cnt_r <= 32'd0;
         end else begin
            deb_cnt_r <= deb_cnt_r + 32'd1;
         end
      end
   end

   assign step_req_s = btn_db_r & ~btn_db_d_r;
   assign div_done_s = (div_cnt_r == DIV_LAST);

   // Phase FSM; cpu_clk and busy are loaded on the same edge as the next state
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         div_cnt_r <= 32'd0;
         cpu_clk_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               div_cnt_r <= 32'd0;
               if (run_sync_r) begin
                  state_r   <= RUN_HI;
                  cpu_clk_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else if (step_req_s) begin
                  state_r   <= STEP_HI;
                  cpu_clk_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  cpu_clk_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            RUN_HI: begin
               busy_r <= 1'b1;
               if (div_done_s) begin
                  state_r   <= RUN_LO;
                  div_cnt_r <= 32'd0;
                  cpu_clk_r <= 1'b0;
               end else begin
                  div_cnt_r <= div_cnt_r + 32'd1;
                  cpu_clk_r <= 1'b1;
               end
            end
            RUN_LO: begin
               if (!div_done_s) begin
                  div_cnt_r <= div_cnt_r + 32'd1;
                  cpu_clk_r <= 1'b0;
                  busy_r    <= 1'b1;
               end else if (run_sync_r) begin
                  state_r   <= RUN_HI;
                  div_cnt_r <= 32'd0;
                  cpu_clk_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  div_cnt_r <= 32'd0;
                  cpu_clk_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            STEP_HI: begin
               busy_r <= 1'b1;
               if (div_done_s) begin
                  state_r   <= STEP_LO;
                  div_cnt_r <= 32'd0;
                  cpu_clk_r <= 1'b0;
               end else begin
                  div_cnt_r <= div_cnt_r + 32'd1;
                  cpu_clk_r <= 1'b1;
               end
            end
            STEP_LO: begin
               cpu_clk_r <= 1'b0;
               if (div_done_s) begin
                  state_r   <= IDLE;
                  div_cnt_r <= 32'd0;
                  busy_r    <= 1'b0;
               end else begin
                  div_cnt_r <= div_cnt_r + 32'd1;
                  busy_r    <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               div_cnt_r <= 32'd0;
               cpu_clk_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_clk = cpu_clk_r;
   assign busy    = busy_r;

`ifdef CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt_r;
   logic        hi_entry_s;

   // Flags the edges on which the FSM enters a HI phase
   always_comb begin
      hi_entry_s = 1'b0;
      case (state_r)
         IDLE:    hi_entry_s = run_sync_r | step_req_s;
         RUN_LO:  hi_entry_s = div_done_s & run_sync_r;
         default: hi_entry_s = 1'b0;
      endcase
   end

   // Issued-cycle counter, wraps at 32 bits
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cycle_cnt_r <= 32'd0;
      end else if (hi_entry_s) begin
         cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_r;
`else
   assign cycle_cnt = 32'h0;
`endif

endmodule
